// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the iterative divider.
// Operation encodings, FSM states, counter sizing and the special-case
// result constants used by div_unit and its testbench.
package div_pkg;

  // Operation select, matches the divop port encoding.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } divop_e;

  // Divider control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  // Special-case results for the default width.
  localparam logic [DIV_WIDTH-1:0] DIV_MOST_NEG = {1'b1, {(DIV_WIDTH-1){1'b0}}};
  localparam logic [DIV_WIDTH-1:0] DIV_ALL_ONES = {DIV_WIDTH{1'b1}};

  // Iteration counter width for an arbitrary operand width.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // DIV and REM are the signed operations (bit 0 clear).
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // REM and REMU return the remainder (bit 1 set).
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring division iteration, purely combinational.
// {rem, quo} is shifted left by one, the divisor is trial-subtracted from the
// partial remainder, and the quotient LSB records whether it fit.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // One extra bit above the shifted remainder acts as the borrow out.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Shift, trial-subtract, and keep the difference when no borrow occurred.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {2'b00, divisor};
    rem_next = shifted[WIDTH:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH+1]) begin
      rem_next    = diff[WIDTH:0];
      quo_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative RISC-V M-extension divider (DIV, DIVU, REM, REMU).
// Operands are latched as magnitudes, WIDTH restoring steps run in CALC, and
// FIX applies signs and the divide-by-zero / signed-overflow results.
// Optional feature macro: DIV_EARLY_OUT_EN -- when defined, divide-by-zero
// and signed overflow skip CALC/FIX and complete directly from IDLE.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       divop,
  input  logic [WIDTH-1:0] opr_a,
  input  logic [WIDTH-1:0] opr_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] opr_res
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_reg, state_next;
  divop_e           op_reg;
  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] a_raw_reg;
  logic [WIDTH-1:0] res_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             qsign_reg, rsign_reg;
  logic             dz_reg, ovf_reg;

  logic             accept;
  logic             in_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             in_dz, in_ovf;
  logic             early;
  logic [WIDTH-1:0] early_res;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] quo_fix, rem_fix, fix_res;

  // Operand conditioning at acceptance: magnitudes, signs and special cases.
  always_comb begin
    accept    = (state_reg == ST_IDLE) && start && !flush;
    in_signed = op_is_signed(divop);
    a_neg     = in_signed & opr_a[WIDTH-1];
    b_neg     = in_signed & opr_b[WIDTH-1];
    a_mag     = a_neg ? ('0 - opr_a) : opr_a;
    b_mag     = b_neg ? ('0 - opr_b) : opr_b;
    in_dz     = (opr_b == '0);
    in_ovf    = in_signed && (opr_a == MOST_NEG) && (opr_b == ALL_ONES);
  end

`ifdef DIV_EARLY_OUT_EN
  // Special cases resolve immediately from the raw operands.
  assign early     = in_dz || in_ovf;
  assign early_res = in_dz  ? (op_is_rem(divop) ? opr_a : ALL_ONES)
                            : (op_is_rem(divop) ? '0    : MOST_NEG);
`else
  // Special cases take the full iterative path and are patched in FIX.
  assign early     = 1'b0;
  assign early_res = '0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (div_reg),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Sign restoration and special-case substitution for the final result.
  always_comb begin
    quo_fix = qsign_reg ? ('0 - quo_reg) : quo_reg;
    rem_fix = rsign_reg ? ('0 - rem_reg[WIDTH-1:0]) : rem_reg[WIDTH-1:0];
    if (dz_reg) begin
      quo_fix = ALL_ONES;
      rem_fix = a_raw_reg;
    end else if (ovf_reg) begin
      quo_fix = MOST_NEG;
      rem_fix = '0;
    end
    fix_res = op_is_rem(op_reg) ? rem_fix : quo_fix;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = early ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_reg == LAST_CNT) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  // Datapath: operand latch, iteration, and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg    <= OP_DIV;
      rem_reg   <= '0;
      quo_reg   <= '0;
      div_reg   <= '0;
      a_raw_reg <= '0;
      res_reg   <= '0;
      cnt_reg   <= '0;
      qsign_reg <= 1'b0;
      rsign_reg <= 1'b0;
      dz_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      op_reg    <= divop_e'(divop);
      rem_reg   <= '0;
      quo_reg   <= a_mag;
      div_reg   <= b_mag;
      a_raw_reg <= opr_a;
      cnt_reg   <= '0;
      qsign_reg <= a_neg ^ b_neg;
      rsign_reg <= a_neg;
      dz_reg    <= in_dz;
      ovf_reg   <= in_ovf;
      if (early) res_reg <= early_res;
    end else if (!flush && state_reg == ST_CALC) begin
      rem_reg <= step_rem;
      quo_reg <= step_quo;
      cnt_reg <= cnt_reg + CNT_W'(1);
    end else if (!flush && state_reg == ST_FIX) begin
      res_reg <= fix_res;
    end
  end

  assign busy    = (state_reg != ST_IDLE);
  assign done    = (state_reg == ST_DONE);
  assign opr_res = res_reg;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit with a result scoreboard.
// Expected results are pushed when an operation is issued and popped when
// done is observed. Honours DIV_EARLY_OUT_EN for special-case timing.
`timescale 1ns/1ps
module tb_div_unit;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  divop;
  logic [31:0] opr_a, opr_b;
  logic        busy, done;
  logic [31:0] opr_res;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] res_seen, exp_seen, last_exp;
  int          edge_seen;     // edge offset (from the start-sampling edge) that raised done
  logic        busy_ok, pulse_ok;

  localparam int NORM_EDGE = 33;
`ifdef DIV_EARLY_OUT_EN
  localparam int SPEC_EDGE = 0;
`else
  localparam int SPEC_EDGE = 33;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          edge_exp;
  } vec_t;

  div_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .divop   (divop),
    .opr_a   (opr_a),
    .opr_b   (opr_b),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .opr_res (opr_res)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model following RISC-V M-extension semantics.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   r = $signed(a) / $signed(b);
      2'b01:   r = a / b;
      2'b10:   r = $signed(a) % $signed(b);
      default: r = a % b;
    endcase
    return r;
  endfunction

  function automatic int model_edge(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return SPEC_EDGE;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return SPEC_EDGE;
    return NORM_EDGE;
  endfunction

  // Issue one operation, wait (bounded) for done, pop the scoreboard.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b1; divop = op; opr_a = a; opr_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    edge_seen = 0;
    busy_ok   = 1'b1;
    while (done !== 1'b1 && edge_seen < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      edge_seen++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    res_seen = opr_res;
    exp_seen = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    last_exp = exp_seen;
    $display("txn op=%0d a=%h b=%h res=%h exp=%h done_edge=%0d", op, a, b, res_seen, exp_seen, edge_seen);
    @(posedge clk); #1;
    pulse_ok = (done === 1'b0) && (busy === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; divop = 2'b00; opr_a = '0; opr_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (opr_res !== 32'd0) begin failures++; $display("FAIL reset_res got=%h exp=0", opr_res); end
    rst = 1'b0;
    last_exp = 32'd0;
  endtask

  task automatic test_unsigned();
    vec_t v[2];
    v[0] = '{OP_DIVU, 32'd100, 32'd7, 32'd14, NORM_EDGE};
    v[1] = '{OP_REMU, 32'd100, 32'd7, 32'd2,  NORM_EDGE};
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, v[i].exp);
      checks++; if (res_seen !== exp_seen) begin failures++; $display("FAIL unsigned[%0d]_res got=%h exp=%h", i, res_seen, exp_seen); end
      checks++; if (edge_seen != v[i].edge_exp) begin failures++; $display("FAIL unsigned[%0d]_timing got=%0d exp=%0d", i, edge_seen, v[i].edge_exp); end
      checks++; if (busy_ok !== 1'b1) begin failures++; $display("FAIL unsigned[%0d]_busy got=%b exp=1", i, busy_ok); end
      checks++; if (pulse_ok !== 1'b1) begin failures++; $display("FAIL unsigned[%0d]_pulse got=%b exp=1", i, pulse_ok); end
    end
  endtask

  task automatic test_signed();
    vec_t v[4];
    v[0] = '{OP_DIV, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, NORM_EDGE};
    v[1] = '{OP_REM, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, NORM_EDGE};
    v[2] = '{OP_DIV, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, NORM_EDGE};
    v[3] = '{OP_REM, 32'd7,         32'hFFFF_FFFE, 32'd1,         NORM_EDGE};
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, v[i].exp);
      checks++; if (res_seen !== exp_seen) begin failures++; $display("FAIL signed[%0d]_res got=%h exp=%h", i, res_seen, exp_seen); end
      checks++; if (edge_seen != v[i].edge_exp) begin failures++; $display("FAIL signed[%0d]_timing got=%0d exp=%0d", i, edge_seen, v[i].edge_exp); end
    end
  endtask

  task automatic test_div_zero();
    vec_t v[4];
    v[0] = '{OP_DIV,  32'd5,         32'd0, 32'hFFFF_FFFF, SPEC_EDGE};
    v[1] = '{OP_REMU, 32'd5,         32'd0, 32'd5,         SPEC_EDGE};
    v[2] = '{OP_DIVU, 32'd5,         32'd0, 32'hFFFF_FFFF, SPEC_EDGE};
    v[3] = '{OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPEC_EDGE};
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, v[i].exp);
      checks++; if (res_seen !== exp_seen) begin failures++; $display("FAIL divzero[%0d]_res got=%h exp=%h", i, res_seen, exp_seen); end
      checks++; if (edge_seen != v[i].edge_exp) begin failures++; $display("FAIL divzero[%0d]_timing got=%0d exp=%0d", i, edge_seen, v[i].edge_exp); end
      checks++; if (pulse_ok !== 1'b1) begin failures++; $display("FAIL divzero[%0d]_pulse got=%b exp=1", i, pulse_ok); end
    end
  endtask

  task automatic test_overflow();
    vec_t v[4];
    v[0] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_EDGE};
    v[1] = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SPEC_EDGE};
    v[2] = '{OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, NORM_EDGE};
    v[3] = '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         NORM_EDGE};
    foreach (v[i]) begin
      do_op(v[i].op, v[i].a, v[i].b, v[i].exp);
      checks++; if (res_seen !== exp_seen) begin failures++; $display("FAIL overflow[%0d]_res got=%h exp=%h", i, res_seen, exp_seen); end
      checks++; if (edge_seen != v[i].edge_exp) begin failures++; $display("FAIL overflow[%0d]_timing got=%0d exp=%0d", i, edge_seen, v[i].edge_exp); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prior;
    logic        saw_done;
    prior = last_exp;
    @(negedge clk);
    start = 1'b1; divop = OP_DIVU; opr_a = 32'd1000; opr_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL flush_done got=%b exp=0", done); end
    checks++; if (opr_res !== prior) begin failures++; $display("FAIL flush_res_held got=%h exp=%h", opr_res, prior); end
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    $display("txn flush op=%0d a=%h b=%h res=%h held=%h", OP_DIVU, 32'd1000, 32'd7, opr_res, prior);
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL flush_no_done got=%b exp=0", saw_done); end
    checks++; if (opr_res !== prior) begin failures++; $display("FAIL flush_res_after got=%h exp=%h", opr_res, prior); end
    do_op(OP_REMU, 32'd1000, 32'd7, 32'd6);
    checks++; if (res_seen !== exp_seen) begin failures++; $display("FAIL flush_restart_res got=%h exp=%h", res_seen, exp_seen); end
    checks++; if (edge_seen != NORM_EDGE) begin failures++; $display("FAIL flush_restart_timing got=%0d exp=%0d", edge_seen, NORM_EDGE); end
  endtask

  task automatic test_start_busy_reset();
    exp_q.push_back(32'd333);
    @(negedge clk);
    start = 1'b1; divop = OP_DIVU; opr_a = 32'd1000; opr_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    edge_seen = 0;
    while (done !== 1'b1 && edge_seen < 100) begin
      if (edge_seen == 3) begin start = 1'b1; divop = OP_REMU; opr_a = 32'd9; opr_b = 32'd4; end
      else start = 1'b0;
      @(posedge clk); #1;
      edge_seen++;
    end
    start = 1'b0;
    res_seen = opr_res;
    exp_seen = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    last_exp = exp_seen;
    $display("txn start_while_busy res=%h exp=%h done_edge=%0d", res_seen, exp_seen, edge_seen);
    checks++; if (res_seen !== exp_seen) begin failures++; $display("FAIL busy_start_res got=%h exp=%h", res_seen, exp_seen); end
    checks++; if (edge_seen != NORM_EDGE) begin failures++; $display("FAIL busy_start_timing got=%0d exp=%0d", edge_seen, NORM_EDGE); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_not_queued got=%b exp=0", busy); end

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; divop = OP_DIV; opr_a = 32'd12345; opr_b = 32'd11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("txn reset_mid_calc busy=%b done=%b res=%h", busy, done, opr_res);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_calc_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_calc_done got=%b exp=0", done); end
    checks++; if (opr_res !== 32'd0) begin failures++; $display("FAIL rst_calc_res got=%h exp=0", opr_res); end
    last_exp = 32'd0;
    do_op(OP_DIV, 32'd12345, 32'd11, 32'd1122);
    checks++; if (res_seen !== exp_seen) begin failures++; $display("FAIL rst_recover_res got=%h exp=%h", res_seen, exp_seen); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  op;
    logic [31:0] a, b;
    int          e;
    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case (i % 4)
        0:       b = $urandom_range(1, 50);
        1:       b = 32'd0 - $urandom_range(1, 50);
        2:       b = $urandom;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      e = model_edge(op, a, b);
      do_op(op, a, b, model(op, a, b));
      checks++; if (res_seen !== exp_seen) begin failures++; $display("FAIL b2b[%0d]_res got=%h exp=%h", i, res_seen, exp_seen); end
      checks++; if (edge_seen != e) begin failures++; $display("FAIL b2b[%0d]_timing got=%0d exp=%0d", i, edge_seen, e); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_flush();
    test_start_busy_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
